// File: rtl/bm_il_pkg.sv
// Shared definitions for the BPM interlock fault logger: state codes,
// fault-word bit positions and log-word layout.
package bm_il_pkg;

  localparam int unsigned IL_ADDR_W  = 14;
  localparam int unsigned IL_FRAME_W = 18;
  localparam int unsigned IL_LOG_W   = IL_FRAME_W + IL_ADDR_W;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_ARMED   = 2'b01;
  localparam logic [1:0] ST_TRIPPED = 2'b10;

  // Fault-word field positions inside il_addr; bit 14 is don't-care upstream.
  localparam int unsigned FW_ZERO_FAULT  = 13;
  localparam int unsigned FW_RSVD        = 12;
  localparam int unsigned FW_X_HIGH      = 11;
  localparam int unsigned FW_X_LOW       = 10;
  localparam int unsigned FW_BPM_IDX_MSB = 9;

  localparam int unsigned LOG_ADDR_LSB  = 0;
  localparam int unsigned LOG_FRAME_LSB = IL_ADDR_W;

  function automatic logic [IL_LOG_W-1:0] make_log_word(
    input logic [IL_FRAME_W-1:0] frame,
    input logic [IL_ADDR_W-1:0]  addr
  );
    return {frame, addr};
  endfunction

endpackage

// File: rtl/il_sync_fifo.sv
// Show-ahead synchronous FIFO with flush, occupancy count and a drop flag
// for pushes refused while full.
module il_sync_fifo #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [W-1:0]               data_i,
  input  logic                       pop_i,
  output logic [W-1:0]               data_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       drop_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          empty, full, pop_ok, push_ok;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (AW+1)'(DEPTH));

  // A pop on a full FIFO frees the slot the simultaneous push needs.
  assign pop_ok  = pop_i && !empty && !flush_i;
  assign push_ok = push_i && (!full || pop_ok) && !flush_i;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_ok) wr_d = wr_q + 1'b1;
      if (pop_ok)  rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= data_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign data_o  = empty ? '0 : mem_q[rd_q];
  assign empty_o = empty;
  assign full_o  = full;
  assign count_o = cnt_q;
  assign drop_o  = push_i && full && !pop_i && !flush_i;

endmodule

// File: rtl/bm_il_fault_logger.sv
// BPM interlock fault logger: per-frame event counting with latched trip,
// first-fault capture and a post-mortem event log FIFO.
module bm_il_fault_logger
  import bm_il_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ADDR_W     = IL_ADDR_W,
  parameter int unsigned FRAME_W    = IL_FRAME_W,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            il_valid,
  input  logic [ADDR_W:0]                 il_addr,
  input  logic                            frame_start,
  input  logic                            arm,
  input  logic                            clear,
  input  logic [CNT_W-1:0]                trip_thresh,
  input  logic                            rd_en,
  output logic                            trip_out,
  output logic [1:0]                      state_o,
  output logic                            first_valid,
  output logic [FRAME_W+ADDR_W-1:0]       first_word,
  output logic [FRAME_W+ADDR_W-1:0]       fifo_data,
  output logic                            fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            overflow,
  output logic [31:0]                     evt_total
);

  localparam int unsigned LOG_W = FRAME_W + ADDR_W;

  logic [1:0]         state_q, state_d;
  logic               trip_q, trip_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [CNT_W-1:0]   fcnt_q, fcnt_d, fcnt_upd;
  logic               first_valid_q, first_valid_d;
  logic [LOG_W-1:0]   first_word_q, first_word_d;
  logic               ovf_q, ovf_d;
  logic [31:0]        total_q, total_d;
  logic               evt, trip_hit, fifo_full, fifo_drop;
  logic [LOG_W-1:0]   log_word;
  logic               unused_addr_msb;

  assign unused_addr_msb = il_addr[ADDR_W];

  // Events are stamped with the frame index after this cycle's increment.
  assign frame_d  = frame_start ? frame_q + 1'b1 : frame_q;
  assign log_word = {frame_d, il_addr[ADDR_W-1:0]};
  assign evt      = il_valid && !clear &&
                    ((state_q == ST_ARMED) || (state_q == ST_TRIPPED));

  assign fcnt_upd = frame_start ? CNT_W'(1)
                  : ((fcnt_q == '1) ? fcnt_q : fcnt_q + 1'b1);
  assign trip_hit = evt && (state_q == ST_ARMED) &&
                    (trip_thresh != '0) && (fcnt_upd >= trip_thresh);

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    if (arm) state_d = ST_ARMED;
        ST_ARMED:   if (trip_hit) state_d = ST_TRIPPED;
        ST_TRIPPED: state_d = ST_TRIPPED;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  assign trip_d = (state_d == ST_TRIPPED);

  always_comb begin
    fcnt_d = fcnt_q;
    if (clear || ((state_q == ST_IDLE) && arm)) fcnt_d = '0;
    else if (evt)                               fcnt_d = fcnt_upd;
    else if (frame_start)                       fcnt_d = '0;
  end

  always_comb begin
    first_valid_d = first_valid_q;
    first_word_d  = first_word_q;
    ovf_d         = ovf_q;
    total_d       = total_q;
    if (clear) begin
      first_valid_d = 1'b0;
      ovf_d         = 1'b0;
      total_d       = '0;
    end else begin
      if (evt && !first_valid_q) begin
        first_valid_d = 1'b1;
        first_word_d  = log_word;
      end
      if (fifo_drop)                 ovf_d   = 1'b1;
      if (evt && (total_q != '1))    total_d = total_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      trip_q        <= 1'b0;
      frame_q       <= '0;
      fcnt_q        <= '0;
      first_valid_q <= 1'b0;
      first_word_q  <= '0;
      ovf_q         <= 1'b0;
      total_q       <= '0;
    end else begin
      state_q       <= state_d;
      trip_q        <= trip_d;
      frame_q       <= frame_d;
      fcnt_q        <= fcnt_d;
      first_valid_q <= first_valid_d;
      first_word_q  <= first_word_d;
      ovf_q         <= ovf_d;
      total_q       <= total_d;
    end
  end

  il_sync_fifo #(
    .W     (LOG_W),
    .DEPTH (FIFO_DEPTH)
  ) u_log_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (clear),
    .push_i  (evt),
    .data_i  (log_word),
    .pop_i   (rd_en),
    .data_o  (fifo_data),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count),
    .drop_o  (fifo_drop)
  );

  logic unused_full;
  assign unused_full = fifo_full;

  assign trip_out    = trip_q;
  assign state_o     = state_q;
  assign first_valid = first_valid_q;
  assign first_word  = first_word_q;
  assign overflow    = ovf_q;
  assign evt_total   = total_q;

endmodule
